// File: rtl/dct_pkg.sv
// Purpose : shared types and constants for the bit-serial DA DCT controller.
// Contents: sequencer state enum, default datapath widths, bit-index width.
package dct_pkg;

   localparam int unsigned DCT_DATA_W = 8;
   localparam int unsigned DCT_ACC_W  = 19;
   localparam int unsigned DCT_N_IN   = 8;
   localparam int unsigned BIT_IDX_W  = $clog2(DCT_DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CAPT  = 2'd2,
      OUT   = 2'd3
   } dct_state_e;

endpackage

// File: rtl/dct_bit_counter.sv
// Purpose : bit-cycle counter with synchronous clear-load, enable and a
//           terminal-count flag; wraps to 0 after LAST.
// Ports   : i_clk, i_rst (sync, active-high), i_load (clear to 0),
//           i_en (advance), o_cnt (current count), o_tc (count == LAST).
module dct_bit_counter #(
   parameter int unsigned W    = 3,
   parameter int unsigned LAST = 7
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;
   logic         w_tc;

   assign w_tc = (r_cnt == W'(LAST));

   // Load has priority over enable so a new block always starts at bit 0.
   always_ff @(posedge i_clk) begin
      if (i_rst)       r_cnt <= '0;
      else if (i_load) r_cnt <= '0;
      else if (i_en)   r_cnt <= w_tc ? '0 : r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;
   assign o_tc  = w_tc;

endmodule

// File: rtl/dct_da_sequencer.sv
// Purpose : controller for the bit-serial distributed-arithmetic DCT datapath.
//           Accepts an 8-sample block, runs DATA_W shift/accumulate cycles
//           (subtract on the sign bit), then captures and holds the result
//           under valid/ready backpressure.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready   block handshake
//           sh_load, sh_en, acc_clr, acc_sub, bit_idx   datapath control
//           acc_result          accumulator value from datapath
//           out_valid/out_ready/out_data   coefficient handshake
//           blk_cnt             handed-off coefficient count (wraps)
//           busy                sequencer not idle
module dct_da_sequencer
   import dct_pkg::*;
#(
   parameter int unsigned DATA_W = DCT_DATA_W,
   parameter int unsigned ACC_W  = DCT_ACC_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       sh_load,
   output logic                       sh_en,
   output logic                       acc_clr,
   output logic                       acc_sub,
   output logic [$clog2(DATA_W)-1:0]  bit_idx,
   input  logic [ACC_W-1:0]           acc_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_data,
   output logic [CNT_W-1:0]           blk_cnt,
   output logic                       busy
);

   localparam int unsigned BIT_W = $clog2(DATA_W);

   dct_state_e         r_state;
   dct_state_e         w_state_nxt;
   logic               w_in_ready;
   logic               w_load;
   logic               w_en;
   logic               w_sub;
   logic               w_capt;
   logic               w_handoff;
   logic               w_tc;
   logic [BIT_W-1:0]   w_bit_idx;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_out_data;
   logic [CNT_W-1:0]   r_blk_cnt;

   // Bit index: cleared on accept, advanced on every shift cycle.
   dct_bit_counter #(
      .W    (BIT_W),
      .LAST (DATA_W - 1)
   ) u_bit_cnt (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (w_load),
      .i_en   (w_en),
      .o_cnt  (w_bit_idx),
      .o_tc   (w_tc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and strobes; everything is forced low while rst is high.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_load      = 1'b0;
      w_en        = 1'b0;
      w_sub       = 1'b0;
      w_capt      = 1'b0;
      w_handoff   = 1'b0;
      if (!rst) begin
         unique case (r_state)
            IDLE: begin
               w_in_ready = 1'b1;
               if (in_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = SHIFT;
               end
            end
            SHIFT: begin
               w_en  = 1'b1;
               w_sub = w_tc;
               if (w_tc) w_state_nxt = CAPT;
            end
            CAPT: begin
               w_capt      = 1'b1;
               w_state_nxt = OUT;
            end
            OUT: begin
               // Handoff and next acceptance may share a cycle.
               if (out_ready) begin
                  w_in_ready = 1'b1;
                  w_handoff  = 1'b1;
                  if (in_valid) begin
                     w_load      = 1'b1;
                     w_state_nxt = SHIFT;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output coefficient register and handoff counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_blk_cnt   <= '0;
      end else begin
         if (w_capt) begin
            r_out_data  <= acc_result;
            r_out_valid <= 1'b1;
         end else if (w_handoff) begin
            r_out_valid <= 1'b0;
         end
         if (w_handoff) r_blk_cnt <= r_blk_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign sh_load   = w_load;
   assign acc_clr   = w_load;
   assign sh_en     = w_en;
   assign acc_sub   = w_sub;
   assign bit_idx   = w_bit_idx;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign blk_cnt   = r_blk_cnt;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dct_da_sequencer.sv
// Purpose : self-checking bench for dct_da_sequencer. A cycle-level reference
//           model tracks "cycles since accept" and predicts every output; the
//           predicted coefficient is queued at capture time and a separate
//           monitor pops and compares it at each consumer handoff.
module tb_dct_da_sequencer;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 19;
   localparam int unsigned CW = 4;
   localparam int unsigned BW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW-1:0] acc_result = '0;
   logic          in_ready, sh_load, sh_en, acc_clr, acc_sub, out_valid, busy;
   logic [BW-1:0] bit_idx;
   logic [AW-1:0] out_data;
   logic [CW-1:0] blk_cnt;

   dct_da_sequencer #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sh_load    (sh_load),
      .sh_en      (sh_en),
      .acc_clr    (acc_clr),
      .acc_sub    (acc_sub),
      .bit_idx    (bit_idx),
      .acc_result (acc_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .blk_cnt    (blk_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;
   bit            tb_b2b = 1'b0;
   logic [AW-1:0] sb_q[$];

   // Reference model: m_ph = -1 idle, 0..DW-1 bit cycle, DW capture, DW+1 holding.
   int            m_ph = -1;
   logic          m_ov = 1'b0;
   logic [AW-1:0] m_od = '0;
   int            m_cnt = 0;
   int            m_last_acc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      bit e_rdy;
      bit e_acc;
      bit e_shift;
      cyc++;
      if (rst) begin
         chk("rst_in_ready", 32'(in_ready), 32'(0));
         chk("rst_sh_load",  32'(sh_load),  32'(0));
         chk("rst_sh_en",    32'(sh_en),    32'(0));
         chk("rst_acc_clr",  32'(acc_clr),  32'(0));
         chk("rst_acc_sub",  32'(acc_sub),  32'(0));
         m_ph = -1; m_ov = 1'b0; m_od = '0; m_cnt = 0; m_last_acc = -1;
         sb_q.delete();
      end else begin
         e_shift = (m_ph >= 0) && (m_ph < int'(DW));
         e_rdy   = (m_ph < 0) || ((m_ph == int'(DW) + 1) && out_ready);
         e_acc   = e_rdy && in_valid;
         chk("in_ready",  32'(in_ready),  32'(e_rdy));
         chk("sh_load",   32'(sh_load),   32'(e_acc));
         chk("acc_clr",   32'(acc_clr),   32'(e_acc));
         chk("sh_en",     32'(sh_en),     32'(e_shift));
         chk("acc_sub",   32'(acc_sub),   32'(m_ph == int'(DW) - 1));
         chk("bit_idx",   32'(bit_idx),   e_shift ? 32'(m_ph) : 32'(0));
         chk("busy",      32'(busy),      32'(m_ph >= 0));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         chk("out_data",  32'(out_data),  32'(m_od));
         chk("blk_cnt",   32'(blk_cnt),   32'(m_cnt));
         if (e_acc) begin
            if (tb_b2b && m_last_acc >= 0)
               chk("accept_spacing", 32'(cyc - m_last_acc), 32'(DW + 2));
            m_last_acc = cyc;
         end
         if (e_shift) begin
            m_ph++;
         end else if (m_ph == int'(DW)) begin
            m_od = acc_result;
            m_ov = 1'b1;
            sb_q.push_back(acc_result);
            m_ph = int'(DW) + 1;
         end else if (m_ph == int'(DW) + 1) begin
            if (out_ready) begin
               m_cnt = (m_cnt + 1) % (1 << CW);
               m_ov  = 1'b0;
               m_ph  = e_acc ? 0 : -1;
            end
         end else if (e_acc) begin
            m_ph = 0;
         end
      end
   end

   // Scoreboard monitor: every handed-off coefficient must match the queued value.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready) begin
         if (sb_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
         else                  chk("sb_coef", 32'(out_data), 32'(sb_q.pop_front()));
      end
   end

   initial begin
      // Reset with in_valid high.
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0; in_valid = 1'b0;

      // Single block with a fixed negative result, then backpressure.
      acc_result = 19'h7FFC1;
      repeat (2) step();
      in_valid = 1'b1; step();
      in_valid = 1'b0;
      repeat (10) step();
      in_valid = 1'b1;
      repeat (6) step();
      out_ready = 1'b1; step();
      out_ready = 1'b0; in_valid = 1'b0;
      acc_result = AW'($urandom);
      repeat (12) step();
      out_ready = 1'b1; step();
      out_ready = 1'b0;
      repeat (2) step();

      // Reset in the middle of the shift phase at bit 4.
      rst = 1'b1; step();
      rst = 1'b0; in_valid = 1'b1; step();
      in_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1; step();
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; step();
      in_valid = 1'b0;
      repeat (12) step();

      // Back-to-back streaming long enough to wrap the 4-bit block counter.
      rst = 1'b1; step();
      rst = 1'b0; tb_b2b = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      repeat (18 * (DW + 2)) begin
         acc_result = AW'($urandom);
         step();
      end
      in_valid = 1'b0;
      repeat (12) step();
      tb_b2b = 1'b0;

      // Randomized traffic with occasional resets.
      repeat (3000) begin
         in_valid   = 1'($urandom_range(0, 1));
         out_ready  = ($urandom_range(0, 3) != 0);
         acc_result = AW'($urandom);
         rst        = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (15) step();

      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
